// File: rtl/display_scan_ctrl.sv
// Multi-digit seven-segment scan engine: per-slot blanking, frame-synchronous
// value capture, leading-zero suppression, enable/freeze and a frame tick.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 120000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 19,
  parameter bit LZ_BLANK     = 1'b1,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] sval;
  logic [NUM_DIGITS-1:0]   sdp;

  logic                  last_cnt, last_idx, boundary, in_blank;
  logic [NUM_DIGITS-1:0] supp;
  logic [NUM_DIGITS-1:0] onehot;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_supp;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign last_cnt  = (cnt == CNT_W'(DIGIT_CYCLES - 1));
  assign last_idx  = (idx == IDX_W'(NUM_DIGITS - 1));
  assign boundary  = en && last_cnt && last_idx;
  assign digit_idx = idx;

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_noblank
      assign in_blank = 1'b0;
    end
  endgenerate

  // A digit is dark when it and every digit above it carry neither a value nor a point.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (sval[4*i +: 4] == 4'h0) && !sdp[i];
      supp[i]  = LZ_BLANK && zero_run && (i != 0);
    end
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    onehot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = sval[4*i +: 4];
        cur_dp    = sdp[i];
        cur_supp  = supp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (en && !in_blank && !cur_supp) begin
      an_d  = ~onehot;
      seg_d = hex7(cur_nib);
      dp_d  = ~cur_dp;
    end
  end

  // Counter/shadow state and registered drive; outputs lag cnt/idx by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      sval       <= '0;
      sdp        <= '0;
      an         <= '1;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_tick <= boundary;
      if (en) begin
        if (last_cnt) begin
          cnt <= '0;
          idx <= last_idx ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (boundary) begin
        sval <= value;
        sdp  <= dp_mask;
      end
    end
  end

endmodule
